// File: rtl/ecc_pkg.sv
// Shared types and default timing for the GF(2^163) Montgomery-ladder scheduler.
// The cycle constants must track the core ROM program segment lengths.
package ecc_pkg;

    localparam int KEY_W     = 163;
    localparam int INIT_CYC  = 24;
    localparam int ITER_CYC  = 48;
    localparam int FINAL_CYC = 96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESTART,
        ST_INIT,
        ST_ITER,
        ST_FINAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ecc_phase_timer.sv
// Loadable 8-bit down-counter; expire is high while the count sits at zero.
module ecc_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = (cnt == 8'd0);

endmodule

// File: rtl/ecc_ladder_sched.sv
// Montgomery-ladder sequencer: scans for the leading key bit, then drives the
// cores through init, one iteration per remaining bit, and affine conversion.
module ecc_ladder_sched #(
    parameter int KEY_W     = ecc_pkg::KEY_W,
    parameter int INIT_CYC  = ecc_pkg::INIT_CYC,
    parameter int ITER_CYC  = ecc_pkg::ITER_CYC,
    parameter int FINAL_CYC = ecc_pkg::FINAL_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] k,
    output logic             core_rst,
    output logic             enable,
    output logic             swap1,
    output logic             swap2,
    output logic [7:0]       bit_idx,
    output logic             busy,
    output logic             done,
    output logic             zero_key
);

    import ecc_pkg::*;

    state_t           state, state_nxt;
    logic [KEY_W-1:0] ks, ks_nxt;
    logic [7:0]       bit_idx_nxt;
    logic             swap1_nxt, swap2_nxt, zero_key_nxt;
    logic             tmr_load, tmr_expire;
    logic [7:0]       tmr_val;

    ecc_phase_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_val),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ks       <= '0;
            bit_idx  <= 8'(KEY_W - 1);
            core_rst <= 1'b0;
            enable   <= 1'b0;
            swap1    <= 1'b0;
            swap2    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero_key <= 1'b0;
        end else begin
            state    <= state_nxt;
            ks       <= ks_nxt;
            bit_idx  <= bit_idx_nxt;
            core_rst <= (state_nxt != ST_RESTART);
            enable   <= (state_nxt == ST_INIT) || (state_nxt == ST_ITER) || (state_nxt == ST_FINAL);
            swap1    <= swap1_nxt;
            swap2    <= swap2_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
            zero_key <= zero_key_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ks_nxt       = ks;
        bit_idx_nxt  = bit_idx;
        swap1_nxt    = swap1;
        swap2_nxt    = swap2;
        zero_key_nxt = zero_key;
        tmr_load     = 1'b0;
        tmr_val      = 8'd0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    ks_nxt       = k;
                    bit_idx_nxt  = 8'(KEY_W - 1);
                    zero_key_nxt = 1'b0;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (ks[KEY_W-1]) begin
                    state_nxt = ST_RESTART;
                end else if (bit_idx == 8'd0) begin
                    zero_key_nxt = 1'b1;
                    state_nxt    = ST_DONE;
                end else begin
                    ks_nxt      = ks << 1;
                    bit_idx_nxt = bit_idx - 8'd1;
                end
            end
            ST_RESTART: begin
                tmr_load  = 1'b1;
                tmr_val   = 8'(INIT_CYC - 1);
                state_nxt = ST_INIT;
            end
            ST_INIT, ST_ITER: begin
                // ks[MSB] is always the previously processed bit (the leading one in INIT)
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (bit_idx == 8'd0) begin
                        tmr_val   = 8'(FINAL_CYC - 1);
                        swap1_nxt = 1'b0;
                        swap2_nxt = 1'b0;
                        state_nxt = ST_FINAL;
                    end else begin
                        tmr_val     = 8'(ITER_CYC - 1);
                        ks_nxt      = ks << 1;
                        bit_idx_nxt = bit_idx - 8'd1;
                        swap1_nxt   = ks[KEY_W-2];
                        swap2_nxt   = ks[KEY_W-1] ^ ks[KEY_W-2];
                        state_nxt   = ST_ITER;
                    end
                end
            end
            ST_FINAL: begin
                if (tmr_expire) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ecc_ladder_sched.sv
// Randomised bench for ecc_ladder_sched: a phase-timeline model predicts every
// output on every cycle, and literal latencies/swap sequences pin the model.
module tb_ecc_ladder_sched;

    localparam int KW    = 163;
    localparam int INITC = 24;
    localparam int ITERC = 48;
    localparam int FINC  = 96;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic          core_rst, enable, swap1, swap2, busy, done, zero_key;
    logic [7:0]    bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    ecc_ladder_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k        (k),
        .core_rst (core_rst),
        .enable   (enable),
        .swap1    (swap1),
        .swap2    (swap2),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done),
        .zero_key (zero_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lead(input logic [KW-1:0] kv);
        for (int i = KW - 1; i >= 0; i--)
            if (kv[i]) return i;
        return -1;
    endfunction

    function automatic int lat(input logic [KW-1:0] kv);
        int m;
        m = lead(kv);
        if (m < 0) return KW + 1;
        return (KW - 1 - m) + 1 + 1 + INITC + m * ITERC + FINC + 1;
    endfunction

    // Expected {core_rst, enable, swap1, swap2, busy, done, zero_key, bit_idx} in run cycle c (1 = first after accept)
    function automatic logic [14:0] exp_at(input logic [KW-1:0] kv, input int c);
        logic cr, en, s1, s2, dn, zk;
        int   bi, m, len, s, t, i;
        cr = 1'b1; en = 1'b0; s1 = 1'b0; s2 = 1'b0; dn = 1'b0; zk = 1'b0; bi = 0;
        m   = lead(kv);
        len = lat(kv);
        s   = KW - m;
        if (c == len) begin
            dn = 1'b1;
            zk = (m < 0);
        end else if (c <= s) begin
            bi = KW - c;
        end else if (c == s + 1) begin
            cr = 1'b0;
            bi = m;
        end else begin
            en = 1'b1;
            t  = c - s - 2;
            if (t < INITC) begin
                bi = m;
            end else begin
                t = t - INITC;
                if (t < m * ITERC) begin
                    i  = m - 1 - t / ITERC;
                    bi = i;
                    s1 = kv[i];
                    s2 = kv[i] ^ kv[i+1];
                end
            end
        end
        return {cr, en, s1, s2, 1'b1, dn, zk, 8'(bi)};
    endfunction

    function automatic logic [KW-1:0] rand_bits();
        logic [KW-1:0] r;
        for (int i = 0; i < KW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Behavioural model state, advanced on each rising edge
    logic [KW-1:0] mk = '0;
    int            mc = 0;
    bit            mvalid = 1'b0;
    bit            m_rstlow = 1'b1;
    logic          m_zk = 1'b0;
    logic [7:0]    m_bidx = 8'd162;

    always @(posedge clk) begin
        if (!rst) begin
            mvalid   = 1'b1;
            mc       = 0;
            m_zk     = 1'b0;
            m_bidx   = 8'(KW - 1);
            m_rstlow = 1'b1;
        end else begin
            m_rstlow = 1'b0;
            if (mc == 0) begin
                if (start && mvalid) begin
                    mk   = k;
                    mc   = 1;
                    m_zk = 1'b0;
                end
            end else if (mc == lat(mk)) begin
                mc     = 0;
                m_bidx = 8'd0;
                if (lead(mk) < 0) m_zk = 1'b1;
            end else begin
                mc++;
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] e, a;
        if (mvalid) begin
            if (mc == 0) e = {~m_rstlow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_zk, m_bidx};
            else         e = exp_at(mk, mc);
            a = {core_rst, enable, swap1, swap2, busy, done, zero_key, bit_idx};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs run_cyc=%0d got=%b expected=%b (cr,en,s1,s2,busy,done,zk,idx)", mc, a, e);
            end
        end
    end

    logic sw1_q[$];
    logic sw2_q[$];
    int   chg_q[$];
    bit   en_seen;

    task automatic do_run(input logic [KW-1:0] kv, input bit noisy, input int exp_lat, input string name);
        int         cyc;
        logic [7:0] prev;
        sw1_q.delete(); sw2_q.delete(); chg_q.delete();
        en_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k     = kv;
        @(negedge clk);
        start = 1'b0;
        k     = rand_bits();
        cyc   = 1;
        prev  = bit_idx;
        while (!done && cyc < 9000) begin
            if (enable) en_seen = 1'b1;
            if (enable && bit_idx != prev) begin
                sw1_q.push_back(swap1);
                sw2_q.push_back(swap2);
                chg_q.push_back(cyc);
            end
            prev = bit_idx;
            if (noisy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                k     = rand_bits();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk(name, done ? cyc : -1, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        logic [KW-1:0] kv;
        int            cnt, bad, m;

        repeat (3) @(negedge clk);
        chk("reset_core_rst", core_rst, 0);
        chk("reset_enable", enable, 0);
        chk("reset_bit_idx", bit_idx, 162);
        chk("reset_busy_done", {busy, done, zero_key, swap1, swap2}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_core_rst", core_rst, 1);

        kv = '0; kv[0] = 1'b1;
        do_run(kv, 1'b0, 285, "latency_k1");
        chk("k1_no_iter", sw1_q.size(), 0);
        chk("k1_zero_key", zero_key, 0);

        kv = '0;
        do_run(kv, 1'b0, 164, "latency_k0");
        chk("k0_zero_key", zero_key, 1);
        chk("k0_enable_seen", en_seen, 0);

        kv = '0; kv[3:0] = 4'b1011;
        do_run(kv, 1'b0, 426, "latency_k1011");
        chk("k1011_windows", sw1_q.size(), 3);
        if (sw1_q.size() == 3) begin
            chk("k1011_swap1", {sw1_q[0], sw1_q[1], sw1_q[2]}, 3'b011);
            chk("k1011_swap2", {sw2_q[0], sw2_q[1], sw2_q[2]}, 3'b110);
            chk("k1011_win_len", {16'(chg_q[1] - chg_q[0]), 16'(chg_q[2] - chg_q[1])}, {16'd48, 16'd48});
            chk("k1011_final_len", 426 - chg_q[2], 48 + 96);
        end

        kv = '0; kv[162] = 1'b1;
        do_run(kv, 1'b0, 7899, "latency_k162");
        bad = 0;
        for (int i = 0; i < sw1_q.size(); i++)
            if (sw1_q[i] !== 1'b0 || sw2_q[i] !== (i == 0)) bad++;
        chk("k162_swaps", {16'(sw1_q.size()), 16'(bad)}, {16'd162, 16'd0});

        kv = rand_bits(); kv[162] = 1'b1;
        @(negedge clk);
        start = 1'b1;
        k     = kv;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (!(enable && bit_idx == 8'd80) && cnt < 9000) begin
            @(negedge clk);
            cnt++;
        end
        chk("reach_iter_idx80", enable && bit_idx == 8'd80, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {core_rst, enable, swap1, swap2, busy, done, zero_key}, 0);
        chk("abort_bit_idx", bit_idx, 162);
        rst = 1'b1;
        @(negedge clk);
        kv = '0; kv[2:0] = 3'b101;
        do_run(kv, 1'b0, 379, "latency_k5");

        kv = '0; m = 20;
        for (int i = 0; i < m; i++) kv[i] = 1'($urandom_range(0, 1));
        kv[m] = 1'b1;
        do_run(kv, 1'b1, lat(kv), "latency_noisy");

        for (int r = 0; r < 6; r++) begin
            kv = '0;
            m  = $urandom_range(1, 40);
            for (int i = 0; i < m; i++) kv[i] = 1'($urandom_range(0, 1));
            kv[m] = 1'b1;
            do_run(kv, r[0], lat(kv), "latency_rand");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
